branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Execute-stage branch resolution and program-counter unit, directly downstream of `brcomp`. It drives `br_unsigned_o` into the comparator and consumes `br_less_i`/`br_equal_i`. From these and the decoded instruction it decides taken/not-taken, owns the PC register, and generates a multi-cycle flush of the younger fetch/decode slots on every redirect. It also flags misaligned control-transfer targets for the trap unit.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `FLUSH_CYCLES`, 2, number of cycles `flush_o` is held after a redirect (legal range 1..7).
- `clk_i`  in  1  clock, all state on rising edge.
- `rst_ni`  in  1  synchronous, active-low reset.
- `stall_i`  in  1  hold PC (hazard/memory stall).
- `is_branch_i`  in  1  valid conditional branch in execute.
- `is_jal_i`  in  1  valid JAL in execute.
- `is_jalr_i`  in  1  valid JALR in execute.
- `funct3_i`  in  3  branch funct3.
- `br_less_i`  in  1  from `brcomp`.
- `br_equal_i`  in  1  from `brcomp`.
- `target_i`  in  32  ALU-computed target address.
- `br_unsigned_o`  out  1  to `brcomp`; combinational.
- `pc_o`  out  32  current fetch PC; registered.
- `taken_o`  out  1  redirect this cycle; combinational.
- `flush_o`  out  1  squash younger stages; registered.
- `misaligned_o`  out  1  misaligned-target pulse; registered.
- `illegal_o`  out  1  reserved funct3 on branch; combinational.

## Operation
- `br_unsigned_o` is 1 iff `funct3_i` is 110 (BLTU) or 111 (BGEU); otherwise 0.
- Condition table:
  - 000 BEQ: eq.
  - 001 BNE: !eq.
  - 100 BLT / 110 BLTU: less.
  - 101 BGE / 111 BGEU: !less.
  - 010/011: not taken, `illegal_o`=1 (only while `is_branch_i`).
- `valid_ctl` = (`is_branch_i` | `is_jal_i` | `is_jalr_i`) & !flush_active. An instruction in execute while `flush_o`=1 is squashed and ignored.
- Control-transfer conditions:
  - `cond` = (`is_branch_i` & condition) | `is_jal_i` | `is_jalr_i`.
  - Effective target = `target_i` with bit0 forced to 0 when `is_jalr_i`.
  - `taken_o` = `valid_ctl` & `cond` & eff_target[1]==0.
  - When `valid_ctl` & `cond` & eff_target[1]==1: no redirect, `misaligned_o`=1 next cycle for exactly one cycle.
- More than one of the `is_*_i` inputs asserted at once is a decoder error. Priority is JALR > JAL > branch.
- Next-PC priority:
  - reset → `RESET_PC`.
  - `taken_o` → eff_target, even if `stall_i`=1.
  - `stall_i` → hold.
  - else → `pc_o`+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Flush counter (3 bits):
  - On `taken_o`, the counter loads `FLUSH_CYCLES`.
  - While nonzero, it decrements each cycle, including during stall.
  - `flush_o` = (counter != 0).

## Timing
- Reset values: `pc_o`=`RESET_PC`, `flush_o`=0, `misaligned_o`=0, counter=0.
- Reset mid-flush clears the counter on the same edge.
- Combinational outputs (`taken_o`, `br_unsigned_o`, `illegal_o`) are 0 when all `is_*_i` are 0.
- Redirect latency: `taken_o` in cycle N → `pc_o`=target and `flush_o`=1 in cycle N+1. `flush_o` stays 1 through cycle N+`FLUSH_CYCLES`.
- A redirect cannot occur while `flush_o`=1, because the instruction is squashed. The counter therefore never reloads mid-flush.
- `misaligned_o` is high in cycle N+1 only. PC continues normally (stall or +4). Recovery is owned by the trap unit.
- `pc_o` changes only on a clock edge and never glitches.

## Structure
- `branch_pkg`:
  - `funct3` enum (`F3_BEQ`..`F3_BGEU`).
  - `PC_W`=32.
  - `PC_INC`=4.
  - Default `FLUSH_CYCLES`.
- Sub-module `br_decide`: pure combinational. Inputs `funct3`, less, equal. Outputs `cond`, `unsigned`, `illegal`. It is reusable by a future branch predictor check.
- `branch_ctrl` holds the PC register, the flush counter and the misaligned flop.

## Test plan
- Reset with `rst_ni`=0 for 2 cycles, then release with no control inputs: `pc_o` = 0, 4, 8, 12 on successive cycles; `flush_o`=0.
- BEQ (`funct3_i`=000), `br_equal_i`=1, `target_i`=32'h100, issued at `pc_o`=8: `taken_o`=1 that cycle. Next cycle `pc_o`=32'h100 and `flush_o`=1 for 2 cycles. A branch presented during the flush is ignored.
- BLTU (`funct3_i`=110): `br_unsigned_o`=1. With `br_less_i`=0: not taken, `pc_o` advances by 4.
- JALR with `target_i`=32'h203: eff_target=32'h202, bit1 set → no redirect, `misaligned_o` pulses 1 cycle. JALR with `target_i`=32'h201: `pc_o`=32'h200.
- `stall_i`=1 with a taken JAL to 32'h40 in the same cycle: `pc_o`=32'h40 next cycle. `stall_i`=1 alone: `pc_o` held.
- `pc_o`=32'hFFFF_FFFC with no control inputs: `pc_o` wraps to 0. Assert `rst_ni`=0 during an active flush: next cycle `flush_o`=0 and `pc_o`=`RESET_PC`.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and constants for the execute-stage branch/PC unit.
// Latency: n/a (declarations only). Backpressure: n/a.
package branch_pkg;

    localparam int              PC_W             = 32;
    localparam logic [PC_W-1:0] PC_INC           = 32'd4;
    localparam int              FLUSH_CNT_W      = 3;
    localparam int unsigned     FLUSH_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_RSV2 = 3'b010,
        F3_RSV3 = 3'b011,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } funct3_e;

    function automatic logic f3_is_unsigned(input funct3_e f3);
        return (f3 == F3_BLTU) || (f3 == F3_BGEU);
    endfunction

endpackage

// File: rtl/br_decide.sv
// Branch condition evaluation from funct3 and comparator flags.
// Latency: purely combinational. Backpressure: none, no state.
module br_decide
    import branch_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       less_i,
    input  logic       equal_i,
    output logic       cond_o,
    output logic       unsigned_o,
    output logic       illegal_o
);

    funct3_e f3;
    assign f3 = funct3_e'(funct3_i);

    always_comb begin
        cond_o     = 1'b0;
        illegal_o  = 1'b0;
        unsigned_o = f3_is_unsigned(f3);
        case (f3)
            F3_BEQ:            cond_o = equal_i;
            F3_BNE:            cond_o = !equal_i;
            F3_BLT,  F3_BLTU:  cond_o = less_i;
            F3_BGE,  F3_BGEU:  cond_o = !less_i;
            default:           illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution, PC register, redirect flush counter and misaligned-target flag.
// Latency: taken/unsigned/illegal combinational; pc/flush/misaligned one cycle after.
// Backpressure: stall_i holds the PC unless a redirect wins; flush counter ignores stall.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned     FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            stall_i,
    input  logic            is_branch_i,
    input  logic            is_jal_i,
    input  logic            is_jalr_i,
    input  logic [2:0]      funct3_i,
    input  logic            br_less_i,
    input  logic            br_equal_i,
    input  logic [PC_W-1:0] target_i,
    output logic            br_unsigned_o,
    output logic [PC_W-1:0] pc_o,
    output logic            taken_o,
    output logic            flush_o,
    output logic            misaligned_o,
    output logic            illegal_o
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LD = FLUSH_CNT_W'(FLUSH_CYCLES);

    logic [PC_W-1:0]        pc_q, pc_d;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic                   misaligned_q, misaligned_d;

    logic            dec_cond, dec_unsigned, dec_illegal;
    logic            flush_active, valid_ctl, cond, fire;
    logic [PC_W-1:0] eff_target;

    br_decide u_br_decide (
        .funct3_i   (funct3_i),
        .less_i     (br_less_i),
        .equal_i    (br_equal_i),
        .cond_o     (dec_cond),
        .unsigned_o (dec_unsigned),
        .illegal_o  (dec_illegal)
    );

    assign flush_active = (flush_cnt_q != '0);
    // Anything sitting in execute during a flush is a squashed younger instruction.
    assign valid_ctl    = (is_branch_i | is_jal_i | is_jalr_i) & !flush_active;

    // JALR wins over JAL over branch; for the condition the OR already encodes that.
    assign cond       = is_jalr_i | is_jal_i | (is_branch_i & dec_cond);
    assign eff_target = is_jalr_i ? {target_i[PC_W-1:1], 1'b0} : target_i;
    assign fire       = valid_ctl & cond;

    assign taken_o       = fire & !eff_target[1];
    assign br_unsigned_o = is_branch_i & dec_unsigned;
    assign illegal_o     = is_branch_i & dec_illegal;

    always_comb begin
        pc_d = pc_q + PC_INC;
        if (taken_o) begin
            pc_d = eff_target;
        end else if (stall_i) begin
            pc_d = pc_q;
        end
    end

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (taken_o) begin
            flush_cnt_d = FLUSH_LD;
        end else if (flush_active) begin
            flush_cnt_d = flush_cnt_q - 1'b1;
        end
    end

    assign misaligned_d = fire & eff_target[1];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q         <= RESET_PC;
            flush_cnt_q  <= '0;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            flush_cnt_q  <= flush_cnt_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign pc_o         = pc_q;
    assign flush_o      = flush_active;
    assign misaligned_o = misaligned_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed cycle-by-cycle vectors for branch_ctrl with hand-computed expectations.
module tb_branch_ctrl;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        br;
        logic        jal;
        logic        jalr;
        logic [2:0]  f3;
        logic        less;
        logic        eq;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic        e_taken;
        logic        e_flush;
        logic        e_mis;
        logic        e_uns;
        logic        e_ill;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        stall_i = 1'b0;
    logic        is_branch_i = 1'b0;
    logic        is_jal_i = 1'b0;
    logic        is_jalr_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic        br_less_i = 1'b0;
    logic        br_equal_i = 1'b0;
    logic [31:0] target_i = 32'h0;
    logic        br_unsigned_o;
    logic [31:0] pc_o;
    logic        taken_o;
    logic        flush_o;
    logic        misaligned_o;
    logic        illegal_o;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    branch_ctrl #(.RESET_PC(32'h0000_0000), .FLUSH_CYCLES(2)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .stall_i       (stall_i),
        .is_branch_i   (is_branch_i),
        .is_jal_i      (is_jal_i),
        .is_jalr_i     (is_jalr_i),
        .funct3_i      (funct3_i),
        .br_less_i     (br_less_i),
        .br_equal_i    (br_equal_i),
        .target_i      (target_i),
        .br_unsigned_o (br_unsigned_o),
        .pc_o          (pc_o),
        .taken_o       (taken_o),
        .flush_o       (flush_o),
        .misaligned_o  (misaligned_o),
        .illegal_o     (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input logic rst_n, input logic stall, input logic br,
                                input logic jal, input logic jalr, input logic [2:0] f3,
                                input logic less, input logic eq, input logic [31:0] tgt,
                                input logic [31:0] e_pc, input logic e_taken,
                                input logic e_flush, input logic e_mis,
                                input logic e_uns, input logic e_ill);
        vec_t v;
        v.rst_n = rst_n; v.stall = stall; v.br = br; v.jal = jal; v.jalr = jalr;
        v.f3 = f3; v.less = less; v.eq = eq; v.tgt = tgt;
        v.e_pc = e_pc; v.e_taken = e_taken; v.e_flush = e_flush; v.e_mis = e_mis;
        v.e_uns = e_uns; v.e_ill = e_ill;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, check before the next edge.
    task automatic apply(input vec_t v, input int idx);
        @(posedge clk_i);
        #1;
        rst_ni      = v.rst_n;
        stall_i     = v.stall;
        is_branch_i = v.br;
        is_jal_i    = v.jal;
        is_jalr_i   = v.jalr;
        funct3_i    = v.f3;
        br_less_i   = v.less;
        br_equal_i  = v.eq;
        target_i    = v.tgt;
        #3;
        chk("pc",         idx, pc_o,                  v.e_pc);
        chk("taken",      idx, {31'b0, taken_o},       {31'b0, v.e_taken});
        chk("flush",      idx, {31'b0, flush_o},       {31'b0, v.e_flush});
        chk("misaligned", idx, {31'b0, misaligned_o},  {31'b0, v.e_mis});
        chk("unsigned",   idx, {31'b0, br_unsigned_o}, {31'b0, v.e_uns});
        chk("illegal",    idx, {31'b0, illegal_o},     {31'b0, v.e_ill});
    endtask

    initial begin
        //          rst stl br jal jalr f3      lt eq tgt            pc             tk fl mi un il
        vecs.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,        32'h0,         0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,        32'h0,         0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,        32'h4,         0, 0, 0, 0, 0));
        // BEQ taken at pc 8
        vecs.push_back(mk(1, 0, 1, 0, 0, 3'b000, 0, 1, 32'h100,      32'h8,         1, 0, 0, 0, 0));
        // squashed branch and JAL during the flush window
        vecs.push_back(mk(1, 0, 1, 0, 0, 3'b000, 0, 1, 32'h300,      32'h100,       0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 3'b000, 0, 0, 32'h500,      32'h104,       0, 1, 0, 0, 0));
        // BLTU not taken, then taken
        vecs.push_back(mk(1, 0, 1, 0, 0, 3'b110, 0, 0, 32'h400,      32'h108,       0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 3'b110, 1, 0, 32'h400,      32'h10C,       1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,        32'h400,       0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,        32'h404,       0, 1, 0, 0, 0));
        // JALR to 0x203 -> 0x202 misaligned
        vecs.push_back(mk(1, 0, 0, 0, 1, 3'b000, 0, 0, 32'h203,      32'h408,       0, 0, 0, 0, 0));
        // reserved funct3
        vecs.push_back(mk(1, 0, 1, 0, 0, 3'b010, 1, 1, 32'h700,      32'h40C,       0, 0, 1, 0, 1));
        // JALR to 0x201 -> 0x200
        vecs.push_back(mk(1, 0, 0, 0, 1, 3'b000, 0, 0, 32'h201,      32'h410,       1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,        32'h200,       0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,        32'h204,       0, 1, 0, 0, 0));
        // stalled JAL still redirects; stall alone holds; counter drains during stall
        vecs.push_back(mk(1, 1, 0, 1, 0, 3'b000, 0, 0, 32'h40,       32'h208,       1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 3'b000, 0, 0, 32'h0,        32'h40,        0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 3'b000, 0, 0, 32'h0,        32'h40,        0, 1, 0, 0, 0));
        // BNE with equal -> not taken
        vecs.push_back(mk(1, 0, 1, 0, 0, 3'b001, 0, 1, 32'h80,       32'h40,        0, 0, 0, 0, 0));
        // BGE with !less -> taken to top of address space
        vecs.push_back(mk(1, 0, 1, 0, 0, 3'b101, 0, 0, 32'hFFFF_FFFC, 32'h44,       1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,        32'hFFFF_FFFC, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,        32'h0,         0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 3'b111, 1, 0, 32'h900,      32'h4,         0, 0, 0, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Reset in the middle of a flush: BLT taken, then reset on the first flush cycle.
        apply(mk(1, 0, 1, 0, 0, 3'b100, 1, 0, 32'h600, 32'h8,   1, 0, 0, 0, 0), 100);
        apply(mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,   32'h600, 0, 1, 0, 0, 0), 101);
        apply(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,   32'h0,   0, 0, 0, 0, 0), 102);
        apply(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,   32'h4,   0, 0, 0, 0, 0), 103);

        // Misaligned pulse lasts one cycle and does not start a flush.
        apply(mk(1, 0, 0, 1, 0, 3'b000, 0, 0, 32'h32,  32'h8,   0, 0, 0, 0, 0), 200);
        apply(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,   32'hC,   0, 0, 1, 0, 0), 201);
        apply(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,   32'h10,  0, 0, 0, 0, 0), 202);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
